// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Holds the arbiter state encoding and parameter defaults.
package mem_arb_pkg;

   localparam int AW_DEF    = 12;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2,
      PROG   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used to track pipeline stall cycles.
// Sticks at all-ones instead of wrapping.
module sat_counter
   import mem_arb_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: step on inc unless already saturated
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port,
// the data port and a programming port, alternating fetch/data.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             i_req,
   input  logic [31:0]      i_addr,
   output logic             i_ack,
   output logic [31:0]      i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [3:0]       d_be,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_ack,
   output logic [31:0]      d_rdata,
   input  logic             prog,
   input  logic             prog_we,
   input  logic [AW-1:0]    prog_addr,
   input  logic [31:0]      prog_din,
   output logic             ram_en,
   output logic [3:0]       ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [31:0]      ram_din,
   input  logic [31:0]      ram_dout,
   output logic             mem_hold,
   output logic [CNT_W-1:0] stall_cnt
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       issue_i;
   logic       issue_d;
   logic       unused_addr_bits;

   assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0],
                               d_addr[31:AW+2], d_addr[1:0]};

   // next state and which port (if any) gets the RAM this cycle
   always_comb begin
      state_d = state_q;
      issue_i = 1'b0;
      issue_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (prog) begin
               state_d = PROG;
            end else if (d_req) begin
               issue_d = 1'b1;
               state_d = D_WAIT;
            end else if (i_req) begin
               issue_i = 1'b1;
               state_d = I_WAIT;
            end
         end
         D_WAIT: begin
            if (prog) begin
               state_d = PROG;
            end else if (i_req) begin
               issue_i = 1'b1;
               state_d = I_WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         I_WAIT: begin
            if (prog) begin
               state_d = PROG;
            end else if (d_req) begin
               issue_d = 1'b1;
               state_d = D_WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         PROG: begin
            if (!prog) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM drive; held quiet while reset is asserted
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 4'h0;
      ram_addr = '0;
      ram_din  = '0;
      if (Rst) begin
         if (state_q == PROG) begin
            if (prog_we) begin
               ram_en   = 1'b1;
               ram_we   = 4'hF;
               ram_addr = prog_addr;
               ram_din  = prog_din;
            end
         end else if (issue_d) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[AW+1:2];
            if (d_we) begin
               ram_we  = d_be;
               ram_din = d_wdata;
            end
         end else if (issue_i) begin
            ram_en   = 1'b1;
            ram_addr = i_addr[AW+1:2];
         end
      end
   end

   // arbiter state register
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign i_ack    = (state_q == I_WAIT);
   assign d_ack    = (state_q == D_WAIT);
   assign i_rdata  = i_ack ? ram_dout : '0;
   assign d_rdata  = d_ack ? ram_dout : '0;
   assign mem_hold = (i_req & ~i_ack) | (d_req & ~d_ack) | prog;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (Rst),
      .inc   (mem_hold),
      .cnt   (stall_cnt)
   );

endmodule
